uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running clock divider producing a single-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a one-entry valid/ack holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      rx_ack,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_busy,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      parity_err
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // Start bit is re-checked on the (OVERSAMPLE/2-1)th tick after the falling edge.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_os_check
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  logic tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  uart_rx_state_t            state_q;
  logic                      rx_meta_q, rx_s_q;
  logic [TW-1:0]             tick_cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q, rx_data_q;
  logic                      rx_valid_q, frame_err_q, overrun_q;
  logic                      tick_done, stop_ok;

  assign tick_done = tick && (tick_cnt_q == TICK_LAST);
  assign stop_ok   = tick_done && (state_q == STOP) && rx_s_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (tick && !rx_s_q) begin
            tick_cnt_q <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              bit_idx_q  <= '0;
              state_q    <= rx_s_q ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_done) begin
            tick_cnt_q          <= '0;
            shift_q[bit_idx_q]  <= rx_s_q;
            bit_idx_q           <= bit_idx_q + 1'b1;
            if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_done) begin
            tick_cnt_q   <= '0;
            parity_err_q <= (^shift_q) ^ rx_s_q;
            state_q      <= STOP;
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_done) begin
            tick_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
        // A held-low line must return high before another start can be seen.
        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (stop_ok) begin
        if (!rx_valid_q || rx_ack) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame-level model queues expected bytes and error counts,
// a monitor pops and compares whenever the DUT presents a new byte.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 3_200_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int          BIT_CLK   = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Start edge to rx_valid: mid stop bit, i.e. 9.5 (or 10.5 with parity) bit periods.
  localparam int NOM_LAT = (PAR ? 21 : 19) * BIT_CLK / 2;

  logic       clk = 1'b0;
  logic       rst, rx, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] sb[$];
  bit         model_full = 1'b0;
  logic [7:0] model_data = 8'h00;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int seen_fe = 0, seen_ov = 0, seen_pe = 0;
  int start_cyc = 0, last_dlv_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame outcome from the handshake rules, applied at mid stop bit.
  task automatic model_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    if (par_flip && PAR) exp_pe++;
    if (!stop_bit) begin
      exp_fe++;
    end else if (model_full) begin
      exp_ov++;
    end else begin
      sb.push_back(d);
      model_full = 1'b1;
      model_data = d;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int low_bits,
                            input bit par_flip, input bit count);
    start_cyc = cyc;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_clk(BIT_CLK);
`endif
    rx = stop_bit;
    wait_clk(8);
    if (count) model_frame(d, stop_bit, par_flip);
    wait_clk(BIT_CLK - 8);
    if (!stop_bit && low_bits > 1) wait_clk((low_bits - 1) * BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    model_full = 1'b0;
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_valid"}, rx_valid, model_full);
    if (model_full) chk({tag, "_data"}, rx_data, model_data);
    chk({tag, "_frame_err_cnt"}, seen_fe, exp_fe);
    chk({tag, "_overrun_cnt"}, seen_ov, exp_ov);
    chk({tag, "_parity_err_cnt"}, seen_pe, exp_pe);
    chk({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  // Monitor: a byte is newly presented when valid rises, or stays high across an ack.
  initial begin : monitor
    bit pv, pa;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (rx_valid && (!pv || pa)) begin
          last_dlv_cyc = cyc;
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL spurious_byte: got %02h expected none", rx_data);
          end else begin
            chk("rx_data_sb", rx_data, sb.pop_front());
          end
        end
        if (frame_err)  seen_fe++;
        if (overrun)    seen_ov++;
        if (parity_err) seen_pe++;
        pv = rx_valid;
        pa = rx_ack;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 200000 clk");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, k;
    logic [7:0] d;
    rx = 1'b1;
    rx_ack = 1'b0;
    rst = 1'b1;
    wait_clk(5);
    chk("reset_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    wait_clk(20);

    // Single byte, no ack
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b1);
    wait_clk(10);
    lat = last_dlv_cyc - start_cyc;
    n_checks++;
    if (lat < NOM_LAT - 4 || lat > NOM_LAT + 8) begin
      n_errors++;
      $display("FAIL a5_latency: got %0d clk expected %0d..%0d", lat, NOM_LAT - 4, NOM_LAT + 8);
    end
    checkpoint("a5");
    do_ack();
    wait_clk(40);

    // Back-to-back with ack 5 clk after the first valid
    fork
      begin
        send_frame(8'h00, 1'b1, 0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b1);
      end
      begin
        k = 0;
        while (!rx_valid && k < 400) begin
          wait_clk(1);
          k++;
        end
        chk("b2b_first_valid_seen", rx_valid, 1'b1);
        wait_clk(5);
        do_ack();
      end
    join
    wait_clk(10);
    checkpoint("b2b");
    do_ack();
    wait_clk(40);

    // Two frames, no ack: second is dropped
    send_frame(8'h12, 1'b1, 0, 1'b0, 1'b1);
    wait_clk(20);
    send_frame(8'h34, 1'b1, 0, 1'b0, 1'b1);
    wait_clk(10);
    checkpoint("overrun");
    do_ack();
    wait_clk(40);

    // Start glitch
    rx = 1'b0;
    wait_clk(8);
    rx = 1'b1;
    wait_clk(40);
    checkpoint("glitch");
    send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b1);
    wait_clk(10);
    checkpoint("after_glitch");
    do_ack();
    wait_clk(40);

    // Bad stop bit, line held low for 3 bit times
    send_frame(8'h3C, 1'b0, 3, 1'b0, 1'b1);
    wait_clk(10);
    checkpoint("frame_err");
    send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b1);
    wait_clk(10);
    checkpoint("after_frame_err");
    do_ack();
    wait_clk(40);

    // Reset in the middle of data bit 4; line stays high afterwards
    fork
      send_frame(8'hF8, 1'b1, 0, 1'b0, 1'b0);
      begin
        wait_clk(5 * BIT_CLK + BIT_CLK / 2);
        chk("busy_before_rst", rx_busy, 1'b1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        model_full = 1'b0;
        chk("rst_outputs", {rx_data, rx_valid, rx_busy, frame_err, overrun, parity_err}, 0);
      end
    join
    wait_clk(20);
    checkpoint("rst");
    send_frame(8'h81, 1'b1, 0, 1'b1, 1'b1);
    wait_clk(10);
    checkpoint("after_rst");
    do_ack();
    wait_clk(40);

    // Random bytes, gaps and acks
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1, 0, 1'b0, 1'b1);
      wait_clk($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    wait_clk(10);
    checkpoint("random");
    do_ack();
    wait_clk(20);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
